// File: rtl/seq_recall_game_pkg.sv
// Shared definitions for the sequence-recall game: state encoding, LFSR
// constants and parameter legality limits.
package seq_recall_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOW  = 3'd1,
        S_ENTER = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    localparam int LFSR_W = 16;
    // Taps x^16 + x^14 + x^13 + x^11 + 1 as state bits 15, 13, 12, 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int DEPTH_MAX = 32;
    localparam int VAL_W_MAX = 8;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seq_recall_game_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads SEED on synchronous reset.
module lfsr16
    import seq_recall_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [LFSR_W-1:0]   o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/seq_recall_game.sv
// Sequence-recall game core: shows DEPTH random values, then checks the
// player's recall entered with inc/submit. All outputs are registered.
module seq_recall_game
    import seq_recall_game_pkg::*;
#(
    parameter int          DEPTH       = 10,
    parameter int          VAL_W       = 5,
    parameter int          SHOW_CYCLES = 50000000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_go,
    input  logic               i_inc,
    input  logic               i_submit,
    output logic [VAL_W-1:0]   o_show_val,
    output logic               o_show_valid,
    output logic [VAL_W-1:0]   o_guess_val,
    output logic [DEPTH-1:0]   o_progress,
    output logic               o_win,
    output logic               o_lose,
    output logic               o_busy,
    output logic [2:0]         o_dbg_state,
    output logic [LFSR_W-1:0]  o_dbg_lfsr
);

    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DEPTH - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SHOW_CYCLES - 1);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("seq_recall_game: DEPTH out of range");
    end
    if (VAL_W < 1 || VAL_W > VAL_W_MAX) begin : g_bad_val_w
        $error("seq_recall_game: VAL_W out of range");
    end
    if (SHOW_CYCLES < 1 || SEED == 16'h0000) begin : g_bad_timing
        $error("seq_recall_game: SHOW_CYCLES or SEED illegal");
    end

    // Handshake: go/inc/submit are single-cycle pulses sampled on the rising
    // edge; every effect is visible on the outputs one clock later.

    logic [LFSR_W-1:0]  w_lfsr;
    logic [VAL_W-1:0]   w_sample;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    assign w_sample = w_lfsr[VAL_W-1:0];

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_next;
    logic [VAL_W-1:0]    r_show_val;
    logic [VAL_W-1:0]    w_show_val_next;
    logic [VAL_W-1:0]    r_guess;
    logic [VAL_W-1:0]    w_guess_next;
    logic [DEPTH-1:0]    r_progress;
    logic [DEPTH-1:0]    w_progress_next;
    logic                r_show_valid;
    logic                r_win;
    logic                r_lose;
    logic                r_busy;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_addr;
    logic [VAL_W-1:0]    r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_timer_next    = r_timer;
        w_show_val_next = r_show_val;
        w_guess_next    = r_guess;
        w_progress_next = r_progress;
        w_mem_we        = 1'b0;
        w_mem_addr      = r_idx;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (i_go) begin
                    w_state_next    = S_SHOW;
                    w_mem_we        = 1'b1;
                    w_mem_addr      = '0;
                    w_show_val_next = w_sample;
                    w_idx_next      = '0;
                    w_timer_next    = '0;
                    w_progress_next = '0;
                    w_guess_next    = '0;
                end
            end
            S_SHOW: begin
                if (r_timer == TIMER_LAST) begin
                    w_timer_next = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_next    = S_ENTER;
                        w_idx_next      = '0;
                        w_show_val_next = '0;
                        w_guess_next    = '0;
                    end else begin
                        w_idx_next      = r_idx + IDX_W'(1);
                        w_mem_we        = 1'b1;
                        w_mem_addr      = r_idx + IDX_W'(1);
                        w_show_val_next = w_sample;
                    end
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            S_ENTER: begin
                // submit wins over a coincident inc: compare the pre-increment guess
                if (i_submit) begin
                    if (r_guess == r_mem[r_idx]) begin
                        if (r_idx == IDX_LAST) begin
                            w_progress_next = '1;
                            w_state_next    = S_WIN;
                        end else begin
                            w_progress_next[r_idx] = 1'b1;
                            w_idx_next             = r_idx + IDX_W'(1);
                            w_guess_next           = '0;
                        end
                    end else begin
                        w_progress_next = '0;
                        w_state_next    = S_LOSE;
                    end
                end else if (i_inc) begin
                    w_guess_next = r_guess + VAL_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_timer      <= '0;
            r_show_val   <= '0;
            r_guess      <= '0;
            r_progress   <= '0;
            r_show_valid <= 1'b0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_idx        <= w_idx_next;
            r_timer      <= w_timer_next;
            r_show_val   <= w_show_val_next;
            r_guess      <= w_guess_next;
            r_progress   <= w_progress_next;
            r_show_valid <= (w_state_next == S_SHOW);
            r_win        <= (w_state_next == S_WIN);
            r_lose       <= (w_state_next == S_LOSE);
            r_busy       <= (w_state_next == S_SHOW) || (w_state_next == S_ENTER);
        end
    end

    // Sequence storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_sample;
        end
    end

    assign o_show_val   = r_show_val;
    assign o_show_valid = r_show_valid;
    assign o_guess_val  = r_guess;
    assign o_progress   = r_progress;
    assign o_win        = r_win;
    assign o_lose       = r_lose;
    assign o_busy       = r_busy;
    assign o_dbg_state  = r_state;
    assign o_dbg_lfsr   = w_lfsr;

endmodule

// File: tb/tb_seq_recall_game.sv
// Self-checking bench for seq_recall_game (DEPTH=4, VAL_W=5, SHOW_CYCLES=3):
// expected outputs are queued as each cycle is driven and compared after the edge.
module tb_seq_recall_game;

    localparam int          DEPTH       = 4;
    localparam int          VAL_W       = 5;
    localparam int          SHOW_CYCLES = 3;
    localparam logic [15:0] SEED        = 16'hACE1;

    typedef struct packed {
        logic [VAL_W-1:0] show_val;
        logic             show_valid;
        logic [VAL_W-1:0] guess;
        logic [DEPTH-1:0] progress;
        logic             win;
        logic             lose;
        logic             busy;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               go;
    logic               inc;
    logic               submit;
    logic [VAL_W-1:0]   show_val;
    logic               show_valid;
    logic [VAL_W-1:0]   guess_val;
    logic [DEPTH-1:0]   progress;
    logic               win;
    logic               lose;
    logic               busy;
    logic [2:0]         dbg_state;
    logic [15:0]        dbg_lfsr;

    exp_t               exp_q[$];
    exp_t               cur_e;
    logic [VAL_W-1:0]   seq [DEPTH];
    logic [15:0]        m_lfsr;
    int                 b_idx;
    int                 n_checks;
    int                 n_errors;

    seq_recall_game #(
        .DEPTH       (DEPTH),
        .VAL_W       (VAL_W),
        .SHOW_CYCLES (SHOW_CYCLES),
        .SEED        (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_go         (go),
        .i_inc        (inc),
        .i_submit     (submit),
        .o_show_val   (show_val),
        .o_show_valid (show_valid),
        .o_guess_val  (guess_val),
        .o_progress   (progress),
        .o_win        (win),
        .o_lose       (lose),
        .o_busy       (busy),
        .o_dbg_state  (dbg_state),
        .o_dbg_lfsr   (dbg_lfsr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shift left, feedback into bit 0
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    // scoreboard: pop one expectation per edge that was driven with one
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("show_val",   32'(show_val),   32'(e.show_val));
            check("show_valid", 32'(show_valid), 32'(e.show_valid));
            check("guess_val",  32'(guess_val),  32'(e.guess));
            check("progress",   32'(progress),   32'(e.progress));
            check("win",        32'(win),        32'(e.win));
            check("lose",       32'(lose),       32'(e.lose));
            check("busy",       32'(busy),       32'(e.busy));
        end
    end

    // driver tasks
    task automatic drive(input logic g, input logic n, input logic s, input logic r);
        @(negedge clk);
        go = g; inc = n; submit = s; rst = r;
        exp_q.push_back(cur_e);
        @(posedge clk);
        #1;
        go = 1'b0; inc = 1'b0; submit = 1'b0; rst = 1'b0;
    endtask

    // Start a round and walk through the display phase. m_lfsr here equals the
    // value the DUT samples at the next edge.
    task automatic do_go(input logic noise);
        cur_e            = '0;
        seq[0]           = m_lfsr[VAL_W-1:0];
        cur_e.show_val   = seq[0];
        cur_e.show_valid = 1'b1;
        cur_e.busy       = 1'b1;
        b_idx            = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            for (int t = 0; t < SHOW_CYCLES; t++) begin
                if (t == SHOW_CYCLES - 1) begin
                    if (k < DEPTH - 1) begin
                        seq[k+1]       = m_lfsr[VAL_W-1:0];
                        cur_e.show_val = seq[k+1];
                    end else begin
                        cur_e.show_val   = '0;
                        cur_e.show_valid = 1'b0;
                    end
                end
                drive(noise && k == 1 && t == 0, noise && t == 1, noise && k == 2 && t == 0, 1'b0);
            end
        end
    endtask

    task automatic press_inc();
        cur_e.guess = cur_e.guess + VAL_W'(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_submit(input logic with_inc);
        if (cur_e.guess == seq[b_idx]) begin
            if (b_idx == DEPTH - 1) begin
                cur_e.progress = '1;
                cur_e.win      = 1'b1;
                cur_e.busy     = 1'b0;
            end else begin
                cur_e.progress[b_idx] = 1'b1;
                b_idx++;
                cur_e.guess = '0;
            end
        end else begin
            cur_e.progress = '0;
            cur_e.lose     = 1'b1;
            cur_e.busy     = 1'b0;
        end
        drive(1'b0, with_inc, 1'b1, 1'b0);
    endtask

    task automatic enter_value(input int v);
        for (int i = 0; i < v; i++) press_inc();
        do_submit(1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        go = 1'b0; inc = 1'b0; submit = 1'b0; rst = 1'b1;
        cur_e = '0;
        b_idx = 0;

        // reset then idle
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // round 1: ignored inputs during display, then a full win; element 0
        // is committed with inc and submit in the same cycle
        do_go(1'b1);
        for (int i = 0; i < int'(seq[0]); i++) press_inc();
        do_submit(1'b1);
        for (int k = 1; k < DEPTH; k++) enter_value(int'(seq[k]));
        drive(1'b0, 1'b1, 1'b1, 1'b0);

        // round 2 from WIN: guess wrap-around, then lose on the second element
        do_go(1'b0);
        for (int i = 0; i < 32; i++) press_inc();
        enter_value(int'(seq[0]));
        enter_value((int'(seq[1]) + 1) % 32);
        drive(1'b0, 1'b1, 1'b1, 1'b0);

        // round 3 from LOSE: reset in ENTER with two elements matched
        do_go(1'b0);
        enter_value(int'(seq[0]));
        enter_value(int'(seq[1]));
        cur_e = '0;
        b_idx = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // fresh round after reset
        do_go(1'b0);
        enter_value(int'(seq[0]));

        @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
